// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, weight-count helper and the loader FSM encoding.
package fft_pkg;

    localparam int unsigned NPOINT_DEF = 3;
    localparam int unsigned DW_DEF     = 16;

    // Complex twiddle weights needed by an FFT of 2**npoint points.
    function automatic int unsigned nw(input int unsigned npoint);
        return npoint * (32'd1 << (npoint - 32'd1));
    endfunction

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FULL = 1'b1
    } load_state_e;

endpackage

// File: rtl/fft_weight_bank.sv
// NW x 2*DW twiddle register file: one write port, every entry visible on flat read buses.
module fft_weight_bank #(
    parameter int unsigned NW = 12,
    parameter int unsigned DW = 16,
    parameter int unsigned AW = $clog2(NW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [2*DW-1:0]   i_wdata,
    output logic [NW*DW-1:0]  o_real_bus,
    output logic [NW*DW-1:0]  o_imag_bus
);

    logic [2*DW-1:0] r_mem [NW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NW); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Entry layout is {real, imag}.
    for (genvar k = 0; k < int'(NW); k++) begin : g_rd
        assign o_real_bus[k*DW +: DW] = r_mem[k][2*DW-1:DW];
        assign o_imag_bus[k*DW +: DW] = r_mem[k][DW-1:0];
    end

endmodule

// File: rtl/fft_weight_loader.sv
// Captures the serial twiddle-weight stream into a register bank and holds data frames
// back from the FFT core until the bank is complete.
module fft_weight_loader
    import fft_pkg::*;
#(
    parameter  int unsigned NPOINT = NPOINT_DEF,
    parameter  int unsigned DW     = DW_DEF,
    localparam int unsigned NW     = nw(NPOINT),
    localparam int unsigned AW     = $clog2(NW),
    localparam int unsigned CW     = $clog2(NW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wt_valid,
    input  logic [DW-1:0]     wt_real,
    input  logic [DW-1:0]     wt_imag,
    input  logic              reload,
    input  logic              din_valid_in,
    output logic              din_valid_out,
    output logic              wt_ready,
    output logic [CW-1:0]     wt_count,
    output logic              wt_overflow,
    output logic              din_dropped,
    output logic [NW*DW-1:0]  wt_real_bus,
    output logic [NW*DW-1:0]  wt_imag_bus
);

    load_state_e r_state, w_state_nxt;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_ready, w_ready_nxt;
    logic          r_overflow, w_overflow_nxt;
    logic          r_dropped, w_dropped_nxt;
    logic          w_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_ready    <= w_ready_nxt;
            r_overflow <= w_overflow_nxt;
            r_dropped  <= w_dropped_nxt;
        end
    end

    // reload takes priority over everything, including a coincident weight.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_count_nxt    = r_count;
        w_ready_nxt    = r_ready;
        w_overflow_nxt = r_overflow;
        w_dropped_nxt  = r_dropped;
        w_we           = 1'b0;
        if (reload) begin
            w_state_nxt    = LOAD;
            w_wr_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_ready_nxt    = 1'b0;
            w_overflow_nxt = 1'b0;
            w_dropped_nxt  = 1'b0;
        end else begin
            if (din_valid_in && !r_ready) begin
                w_dropped_nxt = 1'b1;
            end
            case (r_state)
                LOAD: begin
                    if (wt_valid) begin
                        w_we        = 1'b1;
                        w_count_nxt = r_count + CW'(1);
                        // Pointer parks on the last entry so extra weights can never wrap.
                        if (r_wr_ptr == AW'(NW - 1)) begin
                            w_state_nxt = FULL;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                        end
                    end
                end
                FULL: begin
                    if (wt_valid) begin
                        w_overflow_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = LOAD;
            endcase
        end
    end

    fft_weight_bank #(
        .NW (NW),
        .DW (DW),
        .AW (AW)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_addr     (r_wr_ptr),
        .i_wdata    ({wt_real, wt_imag}),
        .o_real_bus (wt_real_bus),
        .o_imag_bus (wt_imag_bus)
    );

    assign din_valid_out = din_valid_in & r_ready;
    assign wt_ready      = r_ready;
    assign wt_count      = r_count;
    assign wt_overflow   = r_overflow;
    assign din_dropped   = r_dropped;

endmodule
